// File: rtl/pmunit_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// pmunit_cmd_sequencer
// Queued PM-unit command sequencer. Assembles multi-word host commands into a
// small FIFO. It translates each command's virtual source address to a physical
// address using the host-supplied offset. It then drives the DMA engine in
// bounded chunks for undo-log (0x02) and write-back (0x03) commands. Opcode 0x01
// reloads the undo-log pointer from LOG_BASE.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   COMMAND_BUS/VALID     - command word stream (accepted when COMMAND_READY=1)
//   COMMAND_READY         - low while a complete command waits on a full queue
//   LOG_BASE/_VALID       - undo-log base, loaded into log_ptr only in IDLE
//   ADDR_OFFSET/_VALID    - virtual-to-physical offset, latched at any time
//   START_EXECUTION       - sets the sticky run flag
//   DMA_START/SRC/DEST/LEN, DMA_DONE - DMA engine handshake
//   CMD_DONE / CMD_ERROR  - per-command retire / unknown-opcode pulses
//   DONE_COUNT            - wrapping count of retired commands
//   QUEUE_LEVEL           - commands currently queued
//   BUSY                  - FSM not in IDLE
// -----------------------------------------------------------------------------
module pmunit_cmd_sequencer #(
  parameter int COMMAND_WORDS = 5,
  parameter int QUEUE_DEPTH   = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_CHUNK     = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   COMMAND_BUS,
  input  logic                          COMMAND_VALID,
  output logic                          COMMAND_READY,
  input  logic [ADDR_WIDTH-1:0]         LOG_BASE,
  input  logic                          LOG_BASE_VALID,
  input  logic [63:0]                   ADDR_OFFSET,
  input  logic                          ADDR_OFFSET_VALID,
  input  logic                          START_EXECUTION,
  output logic                          DMA_START,
  output logic [ADDR_WIDTH-1:0]         DMA_SRC,
  output logic [ADDR_WIDTH-1:0]         DMA_DEST,
  output logic [31:0]                   DMA_LEN,
  input  logic                          DMA_DONE,
  output logic                          CMD_DONE,
  output logic                          CMD_ERROR,
  output logic [15:0]                   DONE_COUNT,
  output logic [$clog2(QUEUE_DEPTH):0]  QUEUE_LEVEL,
  output logic                          BUSY
);

  localparam int IDX_W   = $clog2(COMMAND_WORDS);
  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int REM_W   = 17;
  localparam int ENTRY_W = 8 + 64 + 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_TRANSLATE = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT      = 3'd4;
  localparam logic [2:0] ST_COMPLETE  = 3'd5;

  // Bytes for the next DMA: the remaining count capped at MAX_CHUNK.
  function automatic logic [31:0] min_chunk(input logic [REM_W-1:0] rem);
    if (32'(rem) > 32'(MAX_CHUNK)) begin
      min_chunk = 32'(MAX_CHUNK);
    end else begin
      min_chunk = 32'(rem);
    end
  endfunction

  // Assembler
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            asm_op_q, asm_op_d;
  logic [63:0]           asm_src_q, asm_src_d;
  logic [15:0]           asm_size_q, asm_size_d;
  logic                  pend_q, pend_d;
  // Queue
  logic [ENTRY_W-1:0]    mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;
  // Host configuration
  logic [ADDR_WIDTH-1:0] offset_q;
  logic                  offset_vld_q;
  logic                  run_q, run_d;
  // Execution
  logic [2:0]            state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [15:0]           size_q, size_d;
  logic [ADDR_WIDTH-1:0] csrc_q, csrc_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, log_q, log_d;
  logic [31:0]           len_q, len_d;
  logic                  dma_start_q, dma_start_d;
  logic                  cmd_done_q, cmd_done_d, cmd_err_q, cmd_err_d;
  logic [15:0]           done_cnt_q, done_cnt_d;

  logic                  word_acc_s, last_word_s, full_s, pop_s, push_req_s, push_s;
  logic [ENTRY_W-1:0]    head_s, push_entry_s;
  logic [ADDR_WIDTH-1:0] phys_s;
  logic [REM_W-1:0]      rem_left_s;
  logic                  unused_ok_s;

  assign word_acc_s   = COMMAND_VALID & ~pend_q;
  assign last_word_s  = word_acc_s && (idx_q == IDX_W'(COMMAND_WORDS - 1));
  assign full_s       = (count_q == LVL_W'(QUEUE_DEPTH));
  // FETCH is only entered with a non-empty queue, so popping there is safe.
  assign pop_s        = (state_q == ST_FETCH);
  // A finished command pushes straight through, or waits in the assembler
  // (dropping COMMAND_READY) until a slot frees; a slot freed by a same-cycle
  // pop counts as free.
  assign push_req_s   = last_word_s | pend_q;
  assign push_s       = push_req_s & (~full_s | pop_s);
  assign push_entry_s = {asm_op_d, asm_src_d, asm_size_d};
  assign head_s       = mem_q[rd_ptr_q];
  assign phys_s       = offset_vld_q ? (csrc_q - offset_q) : csrc_q;
  assign rem_left_s   = rem_q - len_q[REM_W-1:0];
  // Upper address/offset bits beyond ADDR_WIDTH are architecturally ignored.
  assign unused_ok_s  = ^{ADDR_OFFSET, head_s};

  // Assembler: capture the fields of each accepted word and advance the index.
  always_comb begin
    asm_op_d   = asm_op_q;
    asm_src_d  = asm_src_q;
    asm_size_d = asm_size_q;
    idx_d      = idx_q;
    if (word_acc_s) begin
      case (idx_q)
        IDX_W'(0): asm_op_d          = COMMAND_BUS[31:24];
        IDX_W'(1): asm_src_d[63:32]  = COMMAND_BUS;
        IDX_W'(2): asm_src_d[31:0]   = COMMAND_BUS;
        IDX_W'(3): asm_size_d        = COMMAND_BUS[31:16];
        default:   asm_op_d          = asm_op_q;
      endcase
      if (last_word_s) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Queue pointers, occupancy and the pending-command flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pend_d   = pend_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
    if (push_s) begin
      pend_d = 1'b0;
    end else if (push_req_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Run flag: START wins over the idle-and-empty clear.
  always_comb begin
    if (START_EXECUTION) begin
      run_d = 1'b1;
    end else if ((state_q == ST_IDLE) && (count_q == {LVL_W{1'b0}})) begin
      run_d = 1'b0;
    end else begin
      run_d = run_q;
    end
  end

  // Command execution FSM and DMA request generation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    csrc_d      = csrc_q;
    rem_d       = rem_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    log_d       = log_q;
    done_cnt_d  = done_cnt_q;
    dma_start_d = 1'b0;
    cmd_done_d  = 1'b0;
    cmd_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (LOG_BASE_VALID) begin
          log_d = LOG_BASE;
        end else begin
          log_d = log_q;
        end
        if (run_q && (count_q != {LVL_W{1'b0}})) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        op_d    = head_s[87:80];
        csrc_d  = head_s[16 +: ADDR_WIDTH];
        size_d  = head_s[15:0];
        rem_d   = {1'b0, head_s[15:0]};
        state_d = ST_TRANSLATE;
      end
      ST_TRANSLATE: begin
        if (op_q == 8'h01) begin
          log_d      = LOG_BASE;
          cmd_done_d = 1'b1;
          state_d    = ST_COMPLETE;
        end else if ((op_q == 8'h02) || (op_q == 8'h03)) begin
          if (rem_q == {REM_W{1'b0}}) begin
            cmd_done_d = 1'b1;
            state_d    = ST_COMPLETE;
          end else begin
            if (op_q == 8'h02) begin
              src_d = phys_s;
              dst_d = log_q;
            end else begin
              src_d = log_q;
              dst_d = phys_s;
            end
            len_d       = min_chunk(rem_q);
            dma_start_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end else begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (DMA_DONE) begin
          src_d = src_q + ADDR_WIDTH'(len_q);
          dst_d = dst_q + ADDR_WIDTH'(len_q);
          rem_d = rem_left_s;
          if (rem_left_s != {REM_W{1'b0}}) begin
            len_d       = min_chunk(rem_left_s);
            dma_start_d = 1'b1;
            state_d     = ST_ISSUE;
          end else begin
            cmd_done_d = 1'b1;
            state_d    = ST_COMPLETE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_COMPLETE: begin
        done_cnt_d = done_cnt_q + 16'd1;
        if (op_q == 8'h02) begin
          log_d = log_q + ADDR_WIDTH'(size_q);
        end else begin
          log_d = log_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_entry_s;
    end
  end

  // Control and datapath state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= {IDX_W{1'b0}};
      asm_op_q     <= 8'h00;
      asm_src_q    <= 64'h0;
      asm_size_q   <= 16'h0;
      pend_q       <= 1'b0;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {LVL_W{1'b0}};
      offset_q     <= {ADDR_WIDTH{1'b0}};
      offset_vld_q <= 1'b0;
      run_q        <= 1'b0;
      state_q      <= ST_IDLE;
      op_q         <= 8'h00;
      size_q       <= 16'h0;
      csrc_q       <= {ADDR_WIDTH{1'b0}};
      rem_q        <= {REM_W{1'b0}};
      src_q        <= {ADDR_WIDTH{1'b0}};
      dst_q        <= {ADDR_WIDTH{1'b0}};
      len_q        <= 32'h0;
      log_q        <= {ADDR_WIDTH{1'b0}};
      dma_start_q  <= 1'b0;
      cmd_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      done_cnt_q   <= 16'h0;
    end else begin
      idx_q        <= idx_d;
      asm_op_q     <= asm_op_d;
      asm_src_q    <= asm_src_d;
      asm_size_q   <= asm_size_d;
      pend_q       <= pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (ADDR_OFFSET_VALID) begin
        offset_q     <= ADDR_OFFSET[ADDR_WIDTH-1:0];
        offset_vld_q <= 1'b1;
      end else begin
        offset_q     <= offset_q;
        offset_vld_q <= offset_vld_q;
      end
      run_q        <= run_d;
      state_q      <= state_d;
      op_q         <= op_d;
      size_q       <= size_d;
      csrc_q       <= csrc_d;
      rem_q        <= rem_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      log_q        <= log_d;
      dma_start_q  <= dma_start_d;
      cmd_done_q   <= cmd_done_d;
      cmd_err_q    <= cmd_err_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign COMMAND_READY = ~pend_q;
  assign DMA_START     = dma_start_q;
  assign DMA_SRC       = src_q;
  assign DMA_DEST      = dst_q;
  assign DMA_LEN       = len_q;
  assign CMD_DONE      = cmd_done_q;
  assign CMD_ERROR     = cmd_err_q;
  assign DONE_COUNT    = done_cnt_q;
  assign QUEUE_LEVEL   = count_q;
  assign BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pmunit_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pmunit_cmd_sequencer
// Directed self-checking bench. Expected DMA transfers are queued as commands
// are pushed and compared when the sequencer raises DMA_START; a negedge
// monitor records CMD_DONE / CMD_ERROR / DMA_START pulses for ordering checks.
// -----------------------------------------------------------------------------
module tb_pmunit_cmd_sequencer;

  localparam int CW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] COMMAND_BUS;
  logic        COMMAND_VALID;
  logic        COMMAND_READY;
  logic [31:0] LOG_BASE;
  logic        LOG_BASE_VALID;
  logic [63:0] ADDR_OFFSET;
  logic        ADDR_OFFSET_VALID;
  logic        START_EXECUTION;
  logic        DMA_START;
  logic [31:0] DMA_SRC, DMA_DEST, DMA_LEN;
  logic        DMA_DONE;
  logic        CMD_DONE, CMD_ERROR;
  logic [15:0] DONE_COUNT;
  logic [2:0]  QUEUE_LEVEL;
  logic        BUSY;

  pmunit_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .COMMAND_BUS(COMMAND_BUS), .COMMAND_VALID(COMMAND_VALID), .COMMAND_READY(COMMAND_READY),
    .LOG_BASE(LOG_BASE), .LOG_BASE_VALID(LOG_BASE_VALID),
    .ADDR_OFFSET(ADDR_OFFSET), .ADDR_OFFSET_VALID(ADDR_OFFSET_VALID),
    .START_EXECUTION(START_EXECUTION),
    .DMA_START(DMA_START), .DMA_SRC(DMA_SRC), .DMA_DEST(DMA_DEST), .DMA_LEN(DMA_LEN),
    .DMA_DONE(DMA_DONE), .CMD_DONE(CMD_DONE), .CMD_ERROR(CMD_ERROR),
    .DONE_COUNT(DONE_COUNT), .QUEUE_LEVEL(QUEUE_LEVEL), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } dma_t;

  dma_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Pulse monitor
  int         done_pulses  = 0;
  int         err_pulses   = 0;
  int         start_pulses = 0;
  int         evt_n        = 0;
  logic [1:0] evt_code [64];

  always @(negedge clk) begin
    if (CMD_DONE)  done_pulses  <= done_pulses + 1;
    if (CMD_ERROR) err_pulses   <= err_pulses + 1;
    if (DMA_START) start_pulses <= start_pulses + 1;
    if (CMD_DONE || CMD_ERROR) begin
      evt_code[evt_n[5:0]] <= {CMD_ERROR, CMD_DONE};
      evt_n <= evt_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    COMMAND_BUS   = w;
    COMMAND_VALID = 1'b1;
    while (!COMMAND_READY && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 64'(COMMAND_READY), 64'd1);
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [63:0] src, input logic [15:0] size);
    logic [31:0] w;
    for (int k = 0; k < CW; k++) begin
      case (k)
        0:       w = {op, 24'($urandom)};
        1:       w = src[63:32];
        2:       w = src[31:0];
        3:       w = {size, 16'($urandom)};
        default: w = $urandom;
      endcase
      send_word(w);
    end
    COMMAND_VALID = 1'b0;
  endtask

  task automatic expect_dma(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    dma_t e;
    e.src = s; e.dst = d; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic start_pulse();
    START_EXECUTION = 1'b1;
    @(negedge clk);
    START_EXECUTION = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!DMA_START && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("dma_start_seen", 64'(DMA_START), 64'd1);
  endtask

  task automatic compare_dma();
    dma_t e;
    check("dma_sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("dma_src", 64'(DMA_SRC), 64'(e.src));
      check("dma_dest", 64'(DMA_DEST), 64'(e.dst));
      check("dma_len", 64'(DMA_LEN), 64'(e.len));
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    check("dma_start_one_cycle", 64'(DMA_START), 64'd0);
    DMA_DONE = 1'b1;
    @(negedge clk);
    DMA_DONE = 1'b0;
  endtask

  task automatic serve_one(output int lat);
    wait_start(lat);
    compare_dma();
    pulse_done();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((BUSY || QUEUE_LEVEL != 3'd0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("idle_reached", 64'(BUSY), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(COMMAND_READY), 64'd1);
    check({tag, "_pulses_busy"}, 64'({DMA_START, CMD_DONE, CMD_ERROR, BUSY}), 64'd0);
    check({tag, "_dma_bus"}, {DMA_SRC, DMA_DEST}, 64'd0);
    check({tag, "_dma_len"}, 64'(DMA_LEN), 64'd0);
    check({tag, "_done_count"}, 64'(DONE_COUNT), 64'd0);
    check({tag, "_level"}, 64'(QUEUE_LEVEL), 64'd0);
  endtask

  initial begin
    int lat;
    int base_evt, base_err, base_start, base_done;

    reset = 1'b1;
    COMMAND_BUS = 32'h0; COMMAND_VALID = 1'b0;
    LOG_BASE = 32'h0; LOG_BASE_VALID = 1'b0;
    ADDR_OFFSET = 64'h0; ADDR_OFFSET_VALID = 1'b0;
    START_EXECUTION = 1'b0; DMA_DONE = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // Undo-log with offset translation
    ADDR_OFFSET = 64'h1000; ADDR_OFFSET_VALID = 1'b1;
    LOG_BASE = 32'h8000;    LOG_BASE_VALID = 1'b1;
    @(negedge clk);
    ADDR_OFFSET_VALID = 1'b0; LOG_BASE_VALID = 1'b0;
    push_cmd(8'h02, 64'h0000_0000_0000_5000, 16'h0040);
    expect_dma(32'h4000, 32'h8000, 32'h40);
    check("t1_level", 64'(QUEUE_LEVEL), 64'd1);
    start_pulse();
    wait_start(lat);
    check("t1_latency", 64'(lat), 64'd3);
    compare_dma();
    pulse_done();
    check("t1_cmd_done", 64'(CMD_DONE), 64'd1);
    wait_idle();
    check("t1_done_count", 64'(DONE_COUNT), 64'd1);
    check("t1_done_pulses", 64'(done_pulses), 64'd1);

    // Chunked undo-log; DEST starts at log_ptr 0x8040 left by the first command
    push_cmd(8'h02, 64'h0000_0000_0000_5000, 16'h2800);
    expect_dma(32'h4000, 32'h8040, 32'h1000);
    expect_dma(32'h5000, 32'h9040, 32'h1000);
    expect_dma(32'h6000, 32'hA040, 32'h0800);
    start_pulse();
    for (int i = 0; i < 3; i++) serve_one(lat);
    wait_idle();
    check("t2_done_count", 64'(DONE_COUNT), 64'd2);
    check("t2_done_pulses", 64'(done_pulses), 64'd2);

    // Queue overflow: five write-backs with run=0
    LOG_BASE = 32'h8000; LOG_BASE_VALID = 1'b1;
    @(negedge clk);
    LOG_BASE_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(8'h03, 64'(32'h2000 + 32'h100 * i), 16'(16 * (i + 1)));
      expect_dma(32'h8000, 32'h1000 + 32'h100 * i, 32'(16 * (i + 1)));
      if (i == 3) begin
        check("t3_level_full", 64'(QUEUE_LEVEL), 64'd4);
        check("t3_ready_full_no_pend", 64'(COMMAND_READY), 64'd1);
      end
    end
    check("t3_ready_pending", 64'(COMMAND_READY), 64'd0);
    check("t3_level_pending", 64'(QUEUE_LEVEL), 64'd4);
    COMMAND_BUS = 32'hDEAD_BEEF; COMMAND_VALID = 1'b1;
    repeat (3) @(negedge clk);
    COMMAND_VALID = 1'b0;
    check("t3_ignored_level", 64'(QUEUE_LEVEL), 64'd4);
    check("t3_ignored_ready", 64'(COMMAND_READY), 64'd0);
    start_pulse();
    wait_start(lat);
    check("t3_level_push_pop", 64'(QUEUE_LEVEL), 64'd4);
    compare_dma();
    pulse_done();
    for (int i = 1; i < 5; i++) serve_one(lat);
    wait_idle();
    check("t3_done_count", 64'(DONE_COUNT), 64'd7);
    check("t3_ready_after", 64'(COMMAND_READY), 64'd1);

    // Unknown opcode then write-back, no offset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    LOG_BASE = 32'h8000; LOG_BASE_VALID = 1'b1;
    @(negedge clk);
    LOG_BASE_VALID = 1'b0;
    base_evt = evt_n;
    base_err = err_pulses;
    push_cmd(8'h7F, 64'h0000_0000_0000_3000, 16'h0020);
    push_cmd(8'h03, 64'h0000_0000_0000_9000, 16'h0030);
    expect_dma(32'h8000, 32'h9000, 32'h30);
    start_pulse();
    serve_one(lat);
    wait_idle();
    check("t4_err_pulses", 64'(err_pulses - base_err), 64'd1);
    check("t4_evt0_error", 64'(evt_code[base_evt[5:0]]), 64'd2);
    check("t4_evt1_done", 64'(evt_code[6'(base_evt + 1)]), 64'd1);
    check("t4_done_count", 64'(DONE_COUNT), 64'd1);

    // Zero-size undo-log: retires at IDLE+3 without DMA
    base_start = start_pulses;
    push_cmd(8'h02, 64'h0000_0000_0000_1234, 16'h0000);
    start_pulse();
    lat = 0;
    while (!CMD_DONE && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("t5_cmd_done_latency", 64'(lat), 64'd3);
    wait_idle();
    check("t5_no_dma", 64'(start_pulses - base_start), 64'd0);
    check("t5_done_count", 64'(DONE_COUNT), 64'd2);

    // Reset during WAIT; log_ptr still 0x8000
    push_cmd(8'h02, 64'h0000_0000_0000_A000, 16'h0008);
    expect_dma(32'hA000, 32'h8000, 32'h8);
    start_pulse();
    wait_start(lat);
    compare_dma();
    @(negedge clk);
    check("t6_busy_wait", 64'({BUSY, DMA_START}), 64'd2);
    push_cmd(8'h02, 64'h0000_0000_0000_B000, 16'h0004);
    check("t6_level_before", 64'(QUEUE_LEVEL), 64'd1);
    base_done = done_pulses;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    DMA_DONE = 1'b1;
    @(negedge clk);
    DMA_DONE = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("t6");
    check("t6_no_cmd_done", 64'(done_pulses - base_done), 64'd0);
    check("t6_sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
